fp_div_iter: RTL and testbench
==============================

Name: fp_div_iter

Overview:
- Iterative IEEE-754 single-precision divider, Z = X / Y. It is the inverse-operation companion to the FPU multiplier.
- Takes the same split-field operand interface (S/E/M, R_mode) and produces the same result fields and exception flags.
- Adds a start/busy/done handshake, because division runs as a multi-cycle restoring loop instead of a pipeline.

Parameters:
- QNAN_MAN, 23'h400000, mantissa field of the default quiet NaN result.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  launch request; sampled only when busy=0.
- Sx, Sy  in  1  sign of dividend X and divisor Y.
- Ex, Ey  in  8  biased exponents.
- Mx, My  in  23  fraction fields, hidden bit not included.
- R_mode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
- busy  out  1  high in DIV and RND states.
- done  out  1  one-cycle pulse; result valid in that cycle and held afterwards.
- Sz  out  1  result sign.
- Ez  out  8  result exponent.
- Mz  out  23  result fraction.
- invalid_flagex, divzero_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex  out  1 each  exception flags.

Behaviour:
- Reset: state=IDLE; every output 0. Reset wins over start and over any in-flight operation. A reset mid-DIV aborts the operation with no done pulse.
- All outputs are registered. Operands and R_mode are captured at the start edge; input changes after that edge are ignored.
- States: IDLE, DIV, RND, DONE. start is accepted in IDLE or DONE; start while busy=1 is ignored.
- Operand classes: E=0 is zero (denormals flush to zero). E=255 with M=0 is Inf. E=255 with M!=0 is NaN.
- Special cases are resolved at the start edge and go straight to DONE, so done is asserted the cycle after start (latency 1):
  - Any NaN operand, 0/0, or Inf/Inf: Sz=0, Ez=255, Mz=QNAN_MAN, invalid=1.
  - Finite nonzero / 0: signed Inf, divzero=1.
  - Inf / finite: signed Inf, no flags.
  - 0 / nonzero, or finite / Inf: signed zero, zero=1.
- Result sign is always Sx^Sy, except for NaN results.
- Normal path datapath:
  - a={1,Mx}, b={1,My}, remainder r=a (26 bits).
  - DIV runs 26 cycles. Each cycle: if r>=b then qbit=1 and r=r-b, else qbit=0. Then r<<=1 and q={q,qbit}.
- RND state (1 cycle), normalisation and rounding:
  - If q[25]=1: man=q[25:2], g=q[1], s=q[0] | (r!=0), exp=Ex-Ey+127.
  - Else: man=q[24:1], g=q[0], s=(r!=0), exp=Ex-Ey+126.
  - exp is computed as a signed 10-bit value.
  - Round increment: RNE g&(s|man[0]); RTZ 0; +inf (g|s)&~Sz; -inf (g|s)&Sz.
  - If the increment carries out of man, the mantissa becomes 1.0 and exp+1.
  - inexact = g|s.
- Result exceptions after rounding:
  - Overflow (exp>=255): overflow=1 and inexact=1. Magnitude is Inf for RNE; max finite 0x7F7FFFFF for RTZ. For +inf mode: Inf if positive, max finite if negative. For -inf mode: Inf if negative, max finite if positive.
  - Underflow (exp<=0): flush to signed zero with underflow=1, inexact=1, zero=1.
  - Otherwise: Ez=exp[7:0], Mz=man[22:0].
- Normal-path latency: DIV occupies cycles 1..26 after the start edge, RND is cycle 27, done is high in cycle 28.
- done is high for exactly one cycle. The FSM then returns to IDLE and the outputs hold.
- Flags are replaced, not accumulated, on every new operation.

Test Plan:
- 6.0/2.0: Sx=Sy=0, Ex=129, Mx=0x400000, Ey=128, My=0, RNE -> done exactly 28 cycles after start; Ez=128, Mz=0x400000, Sz=0; all flags 0.
- 1.0/3.0 (0x3F800000 / 0x40400000) -> RNE gives {Sz,Ez,Mz}=0x3EAAAAAB with inexact=1; RTZ gives 0x3EAAAAAA. Repeat with Sx=1 in -inf mode -> 0xBEAAAAAB.
- Special cases:
  - 1.0/0.0 -> 0x7F800000 with divzero=1, done one cycle after start.
  - 0/0 -> 0x7FC00000 with invalid=1.
  - Inf/2.0 -> Inf, no flags.
  - 2.0/Inf -> zero with zero=1.
- Overflow: 0x7F000000 / 0x3E800000 -> RNE gives 0x7F800000 with overflow=1, inexact=1; RTZ gives 0x7F7FFFFF.
- Underflow: 0x00800000 / 0x40000000 -> 0x00000000 with underflow=1, inexact=1, zero=1.
- Control:
  - Pulse start again at cycle 5 of an operation -> ignored; the first result is unchanged.
  - Assert RST at cycle 10 of DIV -> next cycle busy=0 and all outputs 0, with no done pulse.
  - A fresh 6.0/2.0 after reset returns the correct result.

Source files
------------

// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 single-precision divider, Z = X / Y.
// A restoring quotient loop produces 26 quotient bits over 26 cycles, and a
// single rounding cycle follows. Special operands finish at the start edge.
// The split S/E/M operand interface and the exception flags are the same as
// on the FPU multiplier.
module fp_div_iter #(
    parameter logic [22:0] QNAN_MAN = 23'h400000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        Sx,
    input  logic        Sy,
    input  logic [7:0]  Ex,
    input  logic [7:0]  Ey,
    input  logic [22:0] Mx,
    input  logic [22:0] My,
    input  logic [1:0]  R_mode,
    output logic        busy,
    output logic        done,
    output logic        Sz,
    output logic [7:0]  Ez,
    output logic [22:0] Mz,
    output logic        invalid_flagex,
    output logic        divzero_flagex,
    output logic        overflow_flagex,
    output logic        underflow_flagex,
    output logic        inexact_flagex,
    output logic        zero_flagex
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RND, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [4:0]          r_cnt;

    // Operands captured at launch; the datapath is deliberately left unreset
    logic                r_sign;
    logic [7:0]          r_ex;
    logic [7:0]          r_ey;
    logic [1:0]          r_rm;
    logic [23:0]         r_b;
    logic [25:0]         r_rem;
    logic [25:0]         r_q;

    logic                w_accept;
    logic                w_zx, w_zy, w_infx, w_infy, w_nanx, w_nany;
    logic                w_special, w_sp_sign, w_sp_inv, w_sp_dz, w_sp_zero;
    logic [7:0]          w_sp_ez;
    logic [22:0]         w_sp_mz;

    logic                w_ge;
    logic [25:0]         w_rem_sub;
    logic [25:0]         w_rem_nxt;

    logic                w_sticky, w_g, w_s, w_inc;
    logic [22:0]         w_frac;
    logic [23:0]         w_frac_rnd;
    logic signed [9:0]   w_base, w_exp, w_exp_f;
    logic [30:0]         w_mag;
    logic                w_ov, w_un, w_ix, w_zr;

    // Rounding increment for the selected mode; lsb only matters for ties-to-even
    function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        case (rm)
            2'b00:   round_inc = g & (s | lsb);
            2'b01:   round_inc = 1'b0;
            2'b10:   round_inc = (g | s) & ~sign;
            default: round_inc = (g | s) & sign;
        endcase
    endfunction

    // Overflow magnitude: Inf when rounding away from zero, otherwise max finite
    function automatic logic [30:0] sat_mag(input logic [1:0] rm, input logic sign);
        if (rm == 2'b00 || (rm == 2'b10 && !sign) || (rm == 2'b11 && sign))
            sat_mag = {8'hFF, 23'h000000};
        else
            sat_mag = {8'hFE, 23'h7FFFFF};
    endfunction

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);

    assign w_zx   = (Ex == 8'h00);
    assign w_zy   = (Ey == 8'h00);
    assign w_infx = (Ex == 8'hFF) && (Mx == 23'h0);
    assign w_infy = (Ey == 8'hFF) && (My == 23'h0);
    assign w_nanx = (Ex == 8'hFF) && (Mx != 23'h0);
    assign w_nany = (Ey == 8'hFF) && (My != 23'h0);

    // Classify live operands and build the special-case result; NaN checks take priority
    always_comb begin
        w_special = 1'b1;
        w_sp_sign = Sx ^ Sy;
        w_sp_ez   = 8'h00;
        w_sp_mz   = 23'h0;
        w_sp_inv  = 1'b0;
        w_sp_dz   = 1'b0;
        w_sp_zero = 1'b0;
        if (w_nanx || w_nany || (w_zx && w_zy) || (w_infx && w_infy)) begin
            w_sp_sign = 1'b0;
            w_sp_ez   = 8'hFF;
            w_sp_mz   = QNAN_MAN;
            w_sp_inv  = 1'b1;
        end else if (w_infx) begin
            w_sp_ez   = 8'hFF;
        end else if (w_zy) begin
            w_sp_ez   = 8'hFF;
            w_sp_dz   = 1'b1;
        end else if (w_zx || w_infy) begin
            w_sp_zero = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    // One restoring step: subtract the divisor when it fits, then shift the remainder
    always_comb begin
        w_ge      = (r_rem >= {2'b00, r_b});
        w_rem_sub = w_ge ? (r_rem - {2'b00, r_b}) : r_rem;
        w_rem_nxt = w_rem_sub << 1;
    end

    // Normalise the quotient, round it, and clamp exponent overflow or underflow
    always_comb begin
        w_sticky = |r_rem;
        w_base   = $signed({2'b00, r_ex}) - $signed({2'b00, r_ey});
        if (r_q[25]) begin
            w_frac = r_q[24:2];
            w_g    = r_q[1];
            w_s    = r_q[0] | w_sticky;
            w_exp  = w_base + 10'sd127;
        end else begin
            w_frac = r_q[23:1];
            w_g    = r_q[0];
            w_s    = w_sticky;
            w_exp  = w_base + 10'sd126;
        end
        w_inc      = round_inc(r_rm, r_sign, w_frac[0], w_g, w_s);
        w_frac_rnd = {1'b0, w_frac} + {23'h0, w_inc};
        // A carry out of the fraction leaves it all-zero, i.e. mantissa 1.0
        w_exp_f    = w_frac_rnd[23] ? (w_exp + 10'sd1) : w_exp;
        w_ov = 1'b0;
        w_un = 1'b0;
        w_zr = 1'b0;
        w_ix = w_g | w_s;
        if (w_exp_f >= 10'sd255) begin
            w_mag = sat_mag(r_rm, r_sign);
            w_ov  = 1'b1;
            w_ix  = 1'b1;
        end else if (w_exp_f <= 10'sd0) begin
            w_mag = 31'h0;
            w_un  = 1'b1;
            w_ix  = 1'b1;
            w_zr  = 1'b1;
        end else begin
            w_mag = {w_exp_f[7:0], w_frac_rnd[22:0]};
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) w_next = w_special ? S_DONE : S_DIV;
                else       w_next = S_IDLE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (r_cnt == 5'd25) w_next = S_RND;
            end
            S_RND: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Iteration counter: restarts on launch and steps once per quotient bit
    always_ff @(posedge CLK) begin
        if (RST)                   r_cnt <= 5'd0;
        else if (w_accept)         r_cnt <= 5'd0;
        else if (r_state == S_DIV) r_cnt <= r_cnt + 5'd1;
    end

    // Capture operands at launch, then develop one quotient bit per DIV cycle
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_sign <= Sx ^ Sy;
            r_ex   <= Ex;
            r_ey   <= Ey;
            r_rm   <= R_mode;
            r_b    <= {1'b1, My};
            r_rem  <= {2'b00, 1'b1, Mx};
            r_q    <= 26'h0;
        end else if (r_state == S_DIV) begin
            r_rem  <= w_rem_nxt;
            r_q    <= {r_q[24:0], w_ge};
        end
    end

    // Result registers: load special results at launch, normal ones in RND, else hold
    always_ff @(posedge CLK) begin
        if (RST) begin
            Sz               <= 1'b0;
            Ez               <= 8'h00;
            Mz               <= 23'h0;
            invalid_flagex   <= 1'b0;
            divzero_flagex   <= 1'b0;
            overflow_flagex  <= 1'b0;
            underflow_flagex <= 1'b0;
            inexact_flagex   <= 1'b0;
            zero_flagex      <= 1'b0;
        end else if (w_accept && w_special) begin
            Sz               <= w_sp_sign;
            Ez               <= w_sp_ez;
            Mz               <= w_sp_mz;
            invalid_flagex   <= w_sp_inv;
            divzero_flagex   <= w_sp_dz;
            overflow_flagex  <= 1'b0;
            underflow_flagex <= 1'b0;
            inexact_flagex   <= 1'b0;
            zero_flagex      <= w_sp_zero;
        end else if (r_state == S_RND) begin
            Sz               <= r_sign;
            Ez               <= w_mag[30:23];
            Mz               <= w_mag[22:0];
            invalid_flagex   <= 1'b0;
            divzero_flagex   <= 1'b0;
            overflow_flagex  <= w_ov;
            underflow_flagex <= w_un;
            inexact_flagex   <= w_ix;
            zero_flagex      <= w_zr;
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: directed vectors with hand-computed results for fp_div_iter.
module tb_fp_div_iter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        Sx, Sy;
    logic [7:0]  Ex, Ey;
    logic [22:0] Mx, My;
    logic [1:0]  R_mode;
    logic        busy, done, Sz;
    logic [7:0]  Ez;
    logic [22:0] Mz;
    logic        invalid_flagex, divzero_flagex, overflow_flagex;
    logic        underflow_flagex, inexact_flagex, zero_flagex;

    int n_cmp = 0;
    int n_mis = 0;

    fp_div_iter dut (
        .CLK(CLK), .RST(RST), .start(start),
        .Sx(Sx), .Sy(Sy), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My), .R_mode(R_mode),
        .busy(busy), .done(done), .Sz(Sz), .Ez(Ez), .Mz(Mz),
        .invalid_flagex(invalid_flagex), .divzero_flagex(divzero_flagex),
        .overflow_flagex(overflow_flagex), .underflow_flagex(underflow_flagex),
        .inexact_flagex(inexact_flagex), .zero_flagex(zero_flagex)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] res_word();
        return {Sz, Ez, Mz};
    endfunction

    function automatic logic [31:0] flag_word();
        return {26'h0, invalid_flagex, divzero_flagex, overflow_flagex,
                underflow_flagex, inexact_flagex, zero_flagex};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // flags packed as {invalid, divzero, overflow, underflow, inexact, zero}
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [1:0] rm, input logic [31:0] exp_res,
                          input logic [5:0] exp_flg, input int exp_lat, input bit poke);
        int lat;
        @(negedge CLK);
        {Sx, Ex, Mx} = x;
        {Sy, Ey, My} = y;
        R_mode = rm;
        start  = 1'b1;
        @(posedge CLK); #1;
        start  = 1'b0;
        {Sx, Ex, Mx} = 32'hFFFF_FFFF;
        {Sy, Ey, My} = 32'h0000_0000;
        R_mode = ~rm;
        lat = 1;
        chk({tag, "_busy"}, {31'h0, busy}, {31'h0, (exp_lat > 1)});
        while (!done && lat < 60) begin
            if (poke && lat == 5) begin
                @(negedge CLK);
                {Sx, Ex, Mx} = 32'h3F80_0000;
                {Sy, Ey, My} = 32'h0000_0000;
                start = 1'b1;
            end
            @(posedge CLK); #1;
            start = 1'b0;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, res_word(), exp_res);
        chk({tag, "_flg"}, flag_word(), {26'h0, exp_flg});
        @(posedge CLK); #1;
        chk({tag, "_pulse"}, {31'h0, done}, 32'h0);
        chk({tag, "_hold"}, res_word(), exp_res);
    endtask

    initial begin
        int lat;
        bit seen_done;
        RST = 1'b1; start = 1'b0; R_mode = 2'b00;
        Sx = 1'b0; Sy = 1'b0; Ex = 8'h0; Ey = 8'h0; Mx = 23'h0; My = 23'h0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_res", res_word(), 32'h0);
        chk("rst_flg", flag_word(), 32'h0);
        chk("rst_ctl", {30'h0, busy, done}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        run_op("div6_2",    32'h40C0_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 6'b000000, 28, 1'b0);
        run_op("third_rne", 32'h3F80_0000, 32'h4040_0000, 2'b00, 32'h3EAA_AAAB, 6'b000010, 28, 1'b0);
        run_op("third_rtz", 32'h3F80_0000, 32'h4040_0000, 2'b01, 32'h3EAA_AAAA, 6'b000010, 28, 1'b0);
        run_op("third_ninf",32'hBF80_0000, 32'h4040_0000, 2'b11, 32'hBEAA_AAAB, 6'b000010, 28, 1'b0);
        run_op("one_zero",  32'h3F80_0000, 32'h0000_0000, 2'b00, 32'h7F80_0000, 6'b010000, 1,  1'b0);
        run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 2'b00, 32'h7FC0_0000, 6'b100000, 1,  1'b0);
        run_op("nan_x",     32'h7FC0_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000, 6'b100000, 1,  1'b0);
        run_op("inf_two",   32'h7F80_0000, 32'h4000_0000, 2'b00, 32'h7F80_0000, 6'b000000, 1,  1'b0);
        run_op("two_inf",   32'h4000_0000, 32'h7F80_0000, 2'b00, 32'h0000_0000, 6'b000001, 1,  1'b0);
        run_op("ovf_rne",   32'h7F00_0000, 32'h3E80_0000, 2'b00, 32'h7F80_0000, 6'b001010, 28, 1'b0);
        run_op("ovf_rtz",   32'h7F00_0000, 32'h3E80_0000, 2'b01, 32'h7F7F_FFFF, 6'b001010, 28, 1'b0);
        run_op("ovf_pinf_n",32'hFF00_0000, 32'h3E80_0000, 2'b10, 32'hFF7F_FFFF, 6'b001010, 28, 1'b0);
        run_op("unf",       32'h0080_0000, 32'h4000_0000, 2'b00, 32'h0000_0000, 6'b000111, 28, 1'b0);
        run_op("ign_start", 32'h40C0_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 6'b000000, 28, 1'b1);

        // Abort an operation with reset at DIV cycle 10
        @(negedge CLK);
        {Sx, Ex, Mx} = 32'h3F80_0000;
        {Sy, Ey, My} = 32'h4040_0000;
        R_mode = 2'b00;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 1;
        seen_done = 1'b0;
        while (lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("abort_ctl", {30'h0, busy, done}, 32'h0);
        chk("abort_res", res_word(), 32'h0);
        chk("abort_flg", flag_word(), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (30) begin
            @(posedge CLK); #1;
            if (done) seen_done = 1'b1;
        end
        chk("abort_nodone", {31'h0, seen_done}, 32'h0);

        run_op("after_rst", 32'h40C0_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 6'b000000, 28, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
